// File: rtl/fp_alu_pkg.sv
// Shared definitions for the FP ALU schedulers: word layout, canonical NaN and the
// in-flight tag carried alongside each adder operation.
package fp_alu_pkg;

  localparam int unsigned FP_W        = 32;
  localparam int unsigned FP_SIGN_BIT = 31;
  localparam logic [FP_W-1:0] FP_QNAN = 32'h7FC00000;

  // Wide enough for the largest supported requester count (8).
  localparam int unsigned IDX_W = 3;

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] index;
  } tag_t;

  function automatic logic [FP_W-1:0] fp_negate(input logic [FP_W-1:0] x);
    return {~x[FP_SIGN_BIT], x[FP_SIGN_BIT-1:0]};
  endfunction

endpackage

// File: rtl/fp_add_sched_if.sv
// Requester, response and shared-adder signals of the adder scheduler.
// The master side is the ALU front-end together with the adder; the slave side is the scheduler.
interface fp_add_sched_if
  import fp_alu_pkg::*;
#(
  parameter int unsigned N_REQ = 4
) ();

  logic [N_REQ-1:0]      req_vld;
  logic [N_REQ-1:0]      req_rdy;
  logic [N_REQ*FP_W-1:0] req_a;
  logic [N_REQ*FP_W-1:0] req_b;
  logic [N_REQ-1:0]      req_sub;
  logic [N_REQ-1:0]      rsp_vld;
  logic [N_REQ-1:0]      rsp_rdy;
  logic [N_REQ*FP_W-1:0] rsp_res;
  logic [N_REQ-1:0]      rsp_ovf;
  logic [FP_W-1:0]       add_a;
  logic [FP_W-1:0]       add_b;
  logic                  add_vld;
  logic [FP_W-1:0]       add_res;
  logic                  add_res_vld;
  logic                  add_ovf;
  logic                  err;

  modport master (
    output req_vld, req_a, req_b, req_sub, rsp_rdy, add_res, add_res_vld, add_ovf,
    input  req_rdy, rsp_vld, rsp_res, rsp_ovf, add_a, add_b, add_vld, err
  );

  modport slave (
    input  req_vld, req_a, req_b, req_sub, rsp_rdy, add_res, add_res_vld, add_ovf,
    output req_rdy, rsp_vld, rsp_res, rsp_ovf, add_a, add_b, add_vld, err
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first set request at or after ptr_i,
// wrapping around. Shared by the adder and multiplier schedulers.
module rr_arbiter #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      logic [IW-1:0] cand;
      cand = IW'((32'(ptr_i) + k) % N);
      if (!any_o && req_i[cand]) begin
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
        any_o       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fp_add_sched.sv
// Shares one external FP adder between N_REQ requesters: round-robin issue, a tag pipe
// matching the adder latency, and a one-entry result buffer per requester.
module fp_add_sched
  import fp_alu_pkg::*;
#(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned ADD_LAT = 1
) (
  input logic           clk,
  input logic           rst,
  fp_add_sched_if.slave bus
);

  localparam int unsigned IW = $clog2(N_REQ);

  logic [N_REQ-1:0] busy_q;
  logic [N_REQ-1:0] elig;
  logic [N_REQ-1:0] gnt;
  logic [IW-1:0]    gnt_idx;
  logic             gnt_any;
  logic [IW-1:0]    ptr_q;
  logic [IW-1:0]    issue_idx_q;

  logic [FP_W-1:0]  add_a_q;
  logic [FP_W-1:0]  add_b_q;
  logic             add_vld_q;
  logic [FP_W-1:0]  sel_a;
  logic [FP_W-1:0]  sel_b;
  logic             sel_sub;

  tag_t             tag_q [ADD_LAT];
  tag_t             tag_out;
  logic             capture;
  logic             lost;
  logic             spurious;

  logic [N_REQ-1:0] rsp_vld_q;
  logic [N_REQ-1:0] rsp_ovf_q;
  logic [N_REQ-1:0] rsp_hs;
  logic [FP_W-1:0]  rsp_res_q [N_REQ];
  logic             err_q;

  assign elig = bus.req_vld & ~busy_q;

  rr_arbiter #(
    .N  (N_REQ),
    .IW (IW)
  ) u_arb (
    .req_i (elig),
    .ptr_i (ptr_q),
    .gnt_o (gnt),
    .idx_o (gnt_idx),
    .any_o (gnt_any)
  );

  // The state registers ignore grants while rst is high, so none are advertised.
  assign bus.req_rdy = rst ? '0 : gnt;

  always_comb begin
    sel_a   = '0;
    sel_b   = '0;
    sel_sub = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) begin
        sel_a   = bus.req_a[FP_W*i +: FP_W];
        sel_b   = bus.req_b[FP_W*i +: FP_W];
        sel_sub = bus.req_sub[i];
      end
    end
  end

  assign tag_out  = tag_q[ADD_LAT-1];
  assign capture  = bus.add_res_vld & tag_out.valid;
  assign lost     = tag_out.valid & ~bus.add_res_vld;
  assign spurious = bus.add_res_vld & ~tag_out.valid;
  assign rsp_hs   = rsp_vld_q & bus.rsp_rdy;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q      <= '0;
      ptr_q       <= '0;
      issue_idx_q <= '0;
      add_a_q     <= '0;
      add_b_q     <= '0;
      add_vld_q   <= 1'b0;
      for (int s = 0; s < ADD_LAT; s++) tag_q[s] <= '0;
      rsp_vld_q   <= '0;
      rsp_ovf_q   <= '0;
      for (int i = 0; i < N_REQ; i++) rsp_res_q[i] <= '0;
      err_q       <= 1'b0;
    end else begin
      add_vld_q <= gnt_any;
      if (gnt_any) begin
        add_a_q     <= sel_a;
        add_b_q     <= sel_sub ? fp_negate(sel_b) : sel_b;
        issue_idx_q <= gnt_idx;
        ptr_q       <= (gnt_idx == IW'(N_REQ - 1)) ? '0 : gnt_idx + IW'(1);
      end

      tag_q[0] <= '{valid: add_vld_q, index: IDX_W'(issue_idx_q)};
      for (int s = 1; s < ADD_LAT; s++) tag_q[s] <= tag_q[s-1];

      for (int i = 0; i < N_REQ; i++) begin
        // A lost result still frees its requester so it can retry.
        if (gnt[i]) begin
          busy_q[i] <= 1'b1;
        end else if (rsp_hs[i] || (lost && tag_out.index == IDX_W'(i))) begin
          busy_q[i] <= 1'b0;
        end

        if (capture && tag_out.index == IDX_W'(i)) begin
          rsp_vld_q[i] <= 1'b1;
          rsp_res_q[i] <= bus.add_res;
          rsp_ovf_q[i] <= bus.add_ovf;
        end else if (rsp_hs[i]) begin
          rsp_vld_q[i] <= 1'b0;
        end
      end

      if (spurious || lost) err_q <= 1'b1;
    end
  end

  assign bus.add_a   = add_a_q;
  assign bus.add_b   = add_b_q;
  assign bus.add_vld = add_vld_q;
  assign bus.rsp_vld = rsp_vld_q;
  assign bus.rsp_ovf = rsp_ovf_q;
  assign bus.err     = err_q;

  for (genvar g = 0; g < N_REQ; g++) begin : g_rsp
    assign bus.rsp_res[FP_W*g +: FP_W] = rsp_res_q[g];
  end

endmodule

// File: tb/tb_fp_add_sched.sv
// Bench for fp_add_sched: behavioural FP adder and scheduler model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_fp_add_sched;
  import fp_alu_pkg::*;

  localparam int unsigned N   = 4;
  localparam int unsigned LAT = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fp_add_sched_if #(.N_REQ(N)) bus ();

  fp_add_sched #(
    .N_REQ   (N),
    .ADD_LAT (LAT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- floating-point reference (normals, zero, inf, nan) ----------------
  function automatic real f2r(input logic [31:0] x);
    logic [10:0] ex;
    if (x[30:23] == 8'h00) return 0.0;
    ex = 11'(x[30:23]) + 11'd896;
    return $bitstoreal({x[31], ex, x[22:0], 29'b0});
  endfunction

  function automatic logic [32:0] r2f(input real r);
    logic [63:0] d;
    int          e;
    d = $realtobits(r);
    if (r == 0.0) return {1'b0, d[63], 31'b0};
    e = int'(d[62:52]) - 896;
    if (e >= 255) return {1'b1, d[63], 8'hFF, 23'b0};
    if (e <= 0) return {1'b0, d[63], 31'b0};
    return {1'b0, d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [32:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    logic a_nan, b_nan, a_inf, b_inf;
    a_nan = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    b_nan = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    a_inf = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    b_inf = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
    if (a_nan || b_nan || (a_inf && b_inf && a[31] != b[31])) return {1'b1, FP_QNAN};
    if (a_inf) return {1'b0, a};
    if (b_inf) return {1'b0, b};
    return r2f(f2r(a) + f2r(b));
  endfunction

  // ---------------- external adder model, reset together with the scheduler ----------------
  logic            spur = 1'b0;
  logic            drop = 1'b0;
  logic [LAT-1:0]  av;
  logic [32:0]     ar [LAT];

  always @(posedge clk) begin
    if (rst) begin
      av <= '0;
    end else begin
      av[0] <= bus.add_vld;
      ar[0] <= fp_add(bus.add_a, bus.add_b);
      for (int s = 1; s < LAT; s++) begin
        av[s] <= av[s-1];
        ar[s] <= ar[s-1];
      end
    end
  end

  assign bus.add_res_vld = (av[LAT-1] & ~drop) | spur;
  assign bus.add_res     = ar[LAT-1][31:0];
  assign bus.add_ovf     = ar[LAT-1][32];

  // ---------------- scheduler model and per-cycle compare ----------------
  int          cyc = 0;
  logic [N-1:0] m_busy, m_rvld, m_rovf, p_on;
  logic [31:0] m_rres [N];
  logic [32:0] p_val [N];
  int          p_due [N];
  int          m_ptr;
  logic        m_err, m_avld;
  logic [31:0] m_aa, m_ab;

  task automatic model_reset();
    m_busy = '0; m_rvld = '0; m_rovf = '0; p_on = '0;
    for (int i = 0; i < N; i++) m_rres[i] = '0;
    m_ptr = 0; m_err = 1'b0; m_avld = 1'b0; m_aa = '0; m_ab = '0;
  endtask

  initial begin
    model_reset();
    forever begin
      int           w;
      logic [N-1:0] eg;
      @(negedge clk);
      w = -1;
      if (!rst) begin
        for (int k = 0; k < N; k++) begin
          int c;
          c = (m_ptr + k) % N;
          if (w < 0 && bus.req_vld[c] && !m_busy[c]) w = c;
        end
      end
      for (int i = 0; i < N; i++) eg[i] = (i == w);

      chk("req_rdy", 32'(bus.req_rdy), 32'(eg));
      chk("add_vld", 32'(bus.add_vld), 32'(m_avld));
      chk("add_a", bus.add_a, m_aa);
      chk("add_b", bus.add_b, m_ab);
      chk("rsp_vld", 32'(bus.rsp_vld), 32'(m_rvld));
      chk("rsp_ovf", 32'(bus.rsp_ovf), 32'(m_rovf));
      for (int i = 0; i < N; i++)
        chk($sformatf("rsp_res%0d", i), bus.rsp_res[32*i +: 32], m_rres[i]);
      chk("err", 32'(bus.err), 32'(m_err));

      if (rst) begin
        model_reset();
      end else begin
        for (int i = 0; i < N; i++) begin
          if (m_rvld[i] && bus.rsp_rdy[i]) begin
            m_rvld[i] = 1'b0;
            m_busy[i] = 1'b0;
          end
          if (p_on[i] && p_due[i] == cyc + 1) begin
            p_on[i] = 1'b0;
            if (drop) begin
              m_err     = 1'b1;
              m_busy[i] = 1'b0;
            end else begin
              m_rvld[i] = 1'b1;
              m_rres[i] = p_val[i][31:0];
              m_rovf[i] = p_val[i][32];
            end
          end
        end
        if (spur) m_err = 1'b1;
        m_avld = (w >= 0);
        if (w >= 0) begin
          m_aa = bus.req_a[32*w +: 32];
          m_ab = bus.req_b[32*w +: 32];
          if (bus.req_sub[w]) m_ab[31] = ~m_ab[31];
          m_busy[w] = 1'b1;
          m_ptr     = (w + 1) % N;
          p_on[w]   = 1'b1;
          p_due[w]  = cyc + 2 + LAT;
          p_val[w]  = fp_add(m_aa, m_ab);
        end
      end
      cyc++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Returns one cycle after the handshake (the add_vld cycle).
  task automatic do_req(input int i, input logic [31:0] a, input logic [31:0] b,
                        input logic sub);
    logic got;
    got = 1'b0;
    bus.req_a[32*i +: 32] = a;
    bus.req_b[32*i +: 32] = b;
    bus.req_sub[i]        = sub;
    bus.req_vld[i]        = 1'b1;
    for (int k = 0; k < 40 && !got; k++) begin
      #1;
      if (bus.req_rdy[i]) got = 1'b1;
      @(posedge clk);
      #1;
    end
    bus.req_vld[i] = 1'b0;
    chk($sformatf("grant_wait%0d", i), 32'(got), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] seq [6];
    logic [N-1:0] rec [16];
    logic [N-1:0] mask;
    int           n0, n2, last, alt_bad, first0, second0;

    bus.req_vld = '0; bus.req_a = '0; bus.req_b = '0; bus.req_sub = '0; bus.rsp_rdy = '0;
    repeat (3) step();
    rst = 1'b0;
    #1;
    chk("rst_req_rdy", 32'(bus.req_rdy), 0);
    chk("rst_rsp_vld", 32'(bus.rsp_vld), 0);
    chk("rst_add_vld", 32'(bus.add_vld), 0);
    chk("rst_add_a", bus.add_a, 0);
    chk("rst_err", 32'(bus.err), 0);

    // 1.0 + 2.0
    do_req(0, 32'h3F800000, 32'h40000000, 1'b0);
    chk("single_add_vld", 32'(bus.add_vld), 1);
    chk("single_add_a", bus.add_a, 32'h3F800000);
    step(); step();
    chk("single_rsp_vld0", 32'(bus.rsp_vld[0]), 1);
    chk("single_res", bus.rsp_res[31:0], 32'h40400000);
    chk("single_ovf", 32'(bus.rsp_ovf[0]), 0);
    bus.rsp_rdy[0] = 1'b1; step(); bus.rsp_rdy[0] = 1'b0;

    // 3.0 - 1.0
    do_req(1, 32'h40400000, 32'h3F800000, 1'b1);
    chk("sub_add_b", bus.add_b, 32'hBF800000);
    step(); step();
    chk("sub_res", bus.rsp_res[63:32], 32'h40000000);
    bus.rsp_rdy[1] = 1'b1; step(); bus.rsp_rdy[1] = 1'b0;

    // Contention from reset, operands (i+1) + 1.0
    rst = 1'b1; step(); rst = 1'b0;
    bus.req_a[31:0]   = 32'h3F800000; bus.req_a[63:32]   = 32'h40000000;
    bus.req_a[95:64]  = 32'h40400000; bus.req_a[127:96]  = 32'h40800000;
    bus.req_b = {4{32'h3F800000}};
    bus.req_sub = '0;
    bus.req_vld = '1;
    for (int k = 0; k < 6; k++) begin
      #1; seq[k] = bus.req_rdy; step();
    end
    bus.req_vld = '0;
    chk("cont_g0", 32'(seq[0]), 1);
    chk("cont_g1", 32'(seq[1]), 2);
    chk("cont_g2", 32'(seq[2]), 4);
    chk("cont_g3", 32'(seq[3]), 8);
    chk("cont_g4", 32'(seq[4]), 0);
    chk("cont_g5", 32'(seq[5]), 0);
    repeat (4) step();
    chk("cont_all_vld", 32'(bus.rsp_vld), 32'hF);
    chk("cont_res2", bus.rsp_res[95:64], 32'h40800000);
    for (int k = 0; k < N; k++) begin
      bus.rsp_rdy[k] = 1'b1; step(); bus.rsp_rdy = '0;
      mask = 4'hF << (k + 1);
      chk($sformatf("cont_drain%0d", k), 32'(bus.rsp_vld), 32'(mask));
    end

    // Fairness: req0 and req2 always valid, responses consumed at once
    bus.rsp_rdy = '1;
    bus.req_vld = 4'b0101;
    for (int k = 0; k < 16; k++) begin
      #1; rec[k] = bus.req_rdy; step();
    end
    bus.req_vld = '0;
    n0 = 0; n2 = 0; last = -1; alt_bad = 0; first0 = -1; second0 = -1;
    for (int k = 0; k < 16; k++) begin
      if (rec[k] == 4'b0001) begin
        n0++;
        if (last == 0) alt_bad++;
        last = 0;
        if (first0 < 0) first0 = k; else if (second0 < 0) second0 = k;
      end else if (rec[k] == 4'b0100) begin
        n2++;
        if (last == 2) alt_bad++;
        last = 2;
      end else if (rec[k] != 4'b0000) begin
        alt_bad++;
      end
    end
    chk("fair_n0", n0, 4);
    chk("fair_n2", n2, 4);
    chk("fair_alt", alt_bad, 0);
    chk("fair_first0", first0, 0);
    chk("fair_gap0", second0 - first0, LAT + 3);
    repeat (6) step();
    bus.rsp_rdy = '0;

    // +Inf + -Inf
    do_req(3, 32'h7F800000, 32'hFF800000, 1'b0);
    step(); step();
    chk("spec_vld3", 32'(bus.rsp_vld[3]), 1);
    chk("spec_res", bus.rsp_res[127:96], 32'h7FC00000);
    chk("spec_ovf", 32'(bus.rsp_ovf[3]), 1);
    bus.rsp_rdy[3] = 1'b1; step(); bus.rsp_rdy[3] = 1'b0;

    // Untagged result
    repeat (2) step();
    spur = 1'b1; step(); spur = 1'b0;
    chk("spur_err", 32'(bus.err), 1);
    repeat (5) step();
    chk("spur_err_hold", 32'(bus.err), 1);

    // Reset one cycle after a grant
    do_req(1, 32'h3F800000, 32'h40000000, 1'b0);
    rst = 1'b1; step(); rst = 1'b0;
    chk("mid_add_vld", 32'(bus.add_vld), 0);
    chk("mid_add_a", bus.add_a, 0);
    chk("mid_err", 32'(bus.err), 0);
    chk("mid_res1", bus.rsp_res[63:32], 0);
    for (int k = 0; k < 6; k++) begin
      chk("mid_no_rsp", 32'(bus.rsp_vld), 0);
      step();
    end

    // Tag without adder result: requester freed, err raised
    drop = 1'b1;
    do_req(0, 32'h3F800000, 32'h3F800000, 1'b0);
    repeat (4) step();
    drop = 1'b0;
    chk("lost_no_rsp", 32'(bus.rsp_vld), 0);
    chk("lost_err", 32'(bus.err), 1);
    do_req(0, 32'h40000000, 32'h40000000, 1'b0);
    step(); step();
    chk("lost_retry_res", bus.rsp_res[31:0], 32'h40800000);
    bus.rsp_rdy[0] = 1'b1; step(); bus.rsp_rdy[0] = 1'b0;

    repeat (3) step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fp_add_sched.md
# fp_add_sched

Round-robin scheduler that shares one `adder_32bit` instance between `N_REQ` independent requesters. It accepts add/subtract requests on per-requester valid/ready ports and issues at most one operation per cycle to the adder. It tracks in-flight operations with a tag pipeline and steers each result into a one-entry per-requester response buffer. It sits between the ALU front-end ports and the shared adder; the adder shares `clk`/`rst` with this block.

## Interface
- `N_REQ`, 4: number of requesters (2..8).
- `ADD_LAT`, 1: adder latency in cycles, from `add_vld` to `add_res_vld`.
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `req_vld` in N_REQ: request valid, one bit per requester.
- `req_rdy` out N_REQ: request accepted this cycle; one-hot or zero.
- `req_a` in N_REQ*32: operand A, requester i at bits [32i+31:32i].
- `req_b` in N_REQ*32: operand B, same packing as `req_a`.
- `req_sub` in N_REQ: 1 = compute A−B.
- `rsp_vld` out N_REQ: result buffer i holds a result.
- `rsp_rdy` in N_REQ: requester i consumes its result.
- `rsp_res` out N_REQ*32: buffered result, same packing as `req_a`.
- `rsp_ovf` out N_REQ: buffered overflow flag.
- `add_a`, `add_b` out 32: registered operands to the adder.
- `add_vld` out 1: registered issue strobe (drives adder `i_vld`).
- `add_res` in 32: adder result (`o_res`).
- `add_res_vld` in 1: adder result valid (`o_res_vld`).
- `add_ovf` in 1: adder overflow flag.
- `err` out 1: sticky flag; an untagged result arrived.

## Operation
- Per-requester `busy[i]`:
  - Set on the grant to i.
  - Cleared on the `rsp_vld[i] & rsp_rdy[i]` handshake.
  - Limits each requester to one operation outstanding or buffered.
- Eligibility: `req_vld[i] & ~busy[i]`.
- Arbitration:
  - Round-robin among eligible requesters; search starts at `ptr`.
  - `req_rdy[i]` is combinational, asserted only for the winner.
  - After a grant to i, `ptr <= (i+1) mod N_REQ`. `ptr` is unchanged when nothing is granted.
- Issue register: on a grant, load `add_a <= req_a[i]` and `add_vld <= 1`.
  - `add_b <= req_sub[i] ? {~req_b[i][31], req_b[i][30:0]} : req_b[i]`. Subtraction is performed by flipping the sign of B.
  - With no grant, `add_vld <= 0` and the operand registers hold their values.
- Tag pipe: `ADD_LAT`-deep shift register of {valid, index}, advanced every cycle.
  - Its stage-0 input is {add_vld, issued index}.
  - Its output is aligned with `add_res_vld`.
- Result capture: when `add_res_vld` is high and the tag is valid, load buffer[tag] with {`add_res`, `add_ovf`} and set `rsp_vld[tag]`.
- `add_res_vld` with an invalid tag: discard the result and set `err`. Only `rst` clears `err`.
- A tag valid without `add_res_vld` is a fault: set `err` and clear `busy[tag]` so the requester is not lost.
- `rsp_vld[i]` clears on handshake. A requester whose `busy` clears this cycle becomes eligible next cycle, not the same cycle.
- Adder special cases (NaN, Inf, zero) pass through unmodified.

## Timing
- Reset values:
  - `req_rdy`, `rsp_vld`, `rsp_ovf`, `add_vld`, `err` = 0.
  - `rsp_res`, `add_a`, `add_b` = 0.
  - `busy` = 0, `ptr` = 0, tag pipe all invalid.
- Latency, for a handshake in cycle t:
  - `add_vld` high in cycle t+1.
  - `add_res_vld` high in cycle t+1+ADD_LAT.
  - `rsp_vld` high in cycle t+2+ADD_LAT (t+3 with the default `ADD_LAT`).
- Throughput: one issue per cycle across distinct requesters; one issue per (ADD_LAT+3) cycles for a single requester that has `rsp_rdy` tied high.
- A grant and a result capture in the same cycle are independent. A grant and a handshake for the same i in the same cycle are impossible, because `busy[i]` is set.
- `rsp_rdy[i]` high while `rsp_vld[i]` is low has no effect.
- Reset mid-operation: all in-flight tags and buffers are dropped. The adder is reset on the same edge, so no stale result arrives.

## Structure
- Shared package `fp_alu_pkg`:
  - `FP_W` = 32.
  - `FP_SIGN_BIT` = 31.
  - Canonical qNaN constant 32'h7FC00000.
  - Tag struct {valid, index}.
- Sub-module `rr_arbiter`, parameterised by `N`. Inputs: request vector, pointer. Outputs: one-hot grant, granted index. Reusable for the later multiplier scheduler.
- The adder is instantiated at the ALU top, not inside this block.

## Test plan
- Single request, ADD_LAT=1: req0 A=0x3F800000, B=0x40000000, sub=0, handshake at cycle 0. Expect `add_vld` at cycle 1, `rsp_vld[0]` at cycle 3, `rsp_res[0]`=0x40400000, `rsp_ovf[0]`=0.
- Subtract: req1 A=0x40400000, B=0x3F800000, sub=1. Expect `add_b`=0xBF800000 and `rsp_res[1]`=0x40000000.
- Contention: all four `req_vld` high from reset with `rsp_rdy`=0. Expect grants 0,1,2,3 on consecutive cycles, then no grants. Each `rsp_vld` holds until its `rsp_rdy` is pulsed.
- Fairness: req0 and req2 continuously valid, `rsp_rdy` tied high. Expect alternating grants 0,2,0,2 with no starvation.
- Special and fault: A=0x7F800000, B=0xFF800000. Expect result 0x7FC00000 with ovf=1. Then inject a spurious `add_res_vld` with no tag: expect `err`=1, held until `rst`.
- Reset mid-flight: assert `rst` one cycle after a grant. Expect all outputs at reset values, no `rsp_vld` afterwards, and `err`=0.
